// File: rtl/bus_display_capture.sv
// Bus-monitor stage feeding the seven-segment decoder.
// Snoops core/RAM bus traffic, captures completed transactions and busy
// statistics, debounces a mode push-button and registers a stable
// 32-bit display word selected by the current mode.
module bus_display_capture #(
  parameter logic [31:0] DISPLAY_ADDR    = 32'h0000_FFF0,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  input  logic             ren,
  input  logic             wen,
  input  logic             busy,
  input  logic             halt,
  input  logic             key_n,
  output logic [1:0]       mode,
  output logic [31:0]      display_word,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] busy_max
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Capture registers
  logic [31:0]      disp_reg;
  logic [31:0]      last_rdata;
  logic [31:0]      last_addr;
  logic [CNT_W-1:0] busy_run;

  // Key path
  logic            key_meta;
  logic            key_sync;
  logic            key_stable;
  logic [DB_W-1:0] db_cnt;

  // Derived per-cycle events
  logic             req;
  logic             done;
  logic             busy_hit;
  logic             key_accept;
  logic             press_accept;
  logic [CNT_W-1:0] txn_inc;
  logic [CNT_W-1:0] run_inc;
  logic [31:0]      stats_word;

  // Completion / busy events and saturating next values
  always_comb begin
    req          = ren | wen;
    done         = req && !busy && !halt;
    busy_hit     = req && busy && !halt;
    txn_inc      = (txn_count == '1) ? txn_count : txn_count + CNT_W'(1);
    run_inc      = (busy_run == '1) ? busy_run : busy_run + CNT_W'(1);
    key_accept   = (key_sync != key_stable) && (db_cnt == DB_LAST);
    press_accept = key_accept && !key_sync;
    stats_word   = {16'(txn_count), 16'(busy_max)};
  end

  // Transaction capture; a simultaneous read+write is treated as a write
  always_ff @(posedge CLK) begin
    if (RST) begin
      disp_reg   <= '0;
      last_rdata <= '0;
      last_addr  <= '0;
      txn_count  <= '0;
    end else if (done) begin
      last_addr <= addr;
      txn_count <= txn_inc;
      if (wen) begin
        if (addr == DISPLAY_ADDR) begin
          disp_reg <= wdata;
        end
      end else begin
        last_rdata <= rdata;
      end
    end
  end

  // Busy-run length and its running maximum, frozen while halted
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_run <= '0;
      busy_max <= '0;
    end else if (!halt) begin
      if (busy_hit) begin
        busy_run <= run_inc;
        if (run_inc > busy_max) begin
          busy_max <= run_inc;
        end
      end else begin
        busy_run <= '0;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous push-button
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  // Debounce: accept a new level only after it has held for DEBOUNCE_CYCLES
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_stable <= 1'b1;
      db_cnt     <= '0;
    end else if (key_sync == key_stable) begin
      db_cnt <= '0;
    end else if (key_accept) begin
      key_stable <= key_sync;
      db_cnt     <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Mode advances once per accepted press; releases are ignored
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode <= 2'd0;
    end else if (press_accept) begin
      mode <= mode + 2'd1;
    end
  end

  // Registered display mux so the decoder never sees live bus data
  always_ff @(posedge CLK) begin
    if (RST) begin
      display_word <= '0;
    end else begin
      case (mode)
        2'd0:    display_word <= disp_reg;
        2'd1:    display_word <= last_rdata;
        2'd2:    display_word <= last_addr;
        default: display_word <= stats_word;
      endcase
    end
  end

endmodule
